pc_fetch_sequencer: RTL and testbench

//  Owns the architectural PC register and sequences instruction fetch around the next-PC datapath.

---
 rtl/mips_fetch_pkg.sv | 21 ++
 rtl/fetch_timeout_ctr.sv | 29 ++
 rtl/pc_fetch_sequencer.sv | 148 ++++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the PC fetch sequencer.
// Defines the FSM state encoding, the instruction width, the PC step and the default reset PC.
package mips_fetch_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DEC,
    S_ERR
  } fetch_state_t;

  localparam int unsigned INST_W           = 32;
  localparam int unsigned PC_STEP          = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic is_taken(input logic jump, input logic br, input logic zero);
    return jump | (br & zero);
  endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Counts consecutive WAIT cycles without a memory response.
// expired fires on the WAIT cycle whose increment would bring the count to WAIT_MAX.
module fetch_timeout_ctr #(
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned CNT_W    = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] cnt;

  // Checking against WAIT_MAX-1 makes the error land after exactly WAIT_MAX cycles in WAIT.
  assign expired = en && (cnt == CNT_W'(WAIT_MAX - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// PC register and instruction-fetch sequencer between imem, decoder and next-PC datapath.
// Optional macro DELAY_SLOT_EN: taken targets apply one instruction later (MIPS delay slot).
module pc_fetch_sequencer
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned CNT_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic              imem_rdy,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst_out,
  output logic [31:0]       pc_out,
  input  logic              dec_valid,
  input  logic              jump,
  input  logic              br,
  input  logic              zero,
  input  logic              halt,
  input  logic [31:0]       nextpc_in,
  output logic              busy,
  output logic              fetch_err
);

  fetch_state_t state, state_next;

  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] pc_seq;
  logic        latch_inst;
  logic        commit;
  logic        ctr_clr;
  logic        ctr_en;
  logic        ctr_expired;
  logic        taken;

  fetch_timeout_ctr #(
    .WAIT_MAX (WAIT_MAX),
    .CNT_W    (CNT_W)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clr     (ctr_clr),
    .en      (ctr_en),
    .expired (ctr_expired)
  );

  assign taken  = is_taken(jump, br, zero);
  assign pc_seq = pc + 32'(PC_STEP);

  always_comb begin
    state_next = state;
    latch_inst = 1'b0;
    commit     = 1'b0;
    ctr_clr    = 1'b0;
    ctr_en     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_REQ;
      end
      S_REQ: begin
        if (imem_rdy) begin
          latch_inst = 1'b1;
          state_next = S_DEC;
        end else begin
          ctr_clr    = 1'b1;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rdy) begin
          latch_inst = 1'b1;
          state_next = S_DEC;
        end else begin
          ctr_en = 1'b1;
          if (ctr_expired) state_next = S_ERR;
        end
      end
      S_DEC: begin
        if (dec_valid && !stall) begin
          commit     = 1'b1;
          state_next = halt ? S_IDLE : S_REQ;
        end
      end
      S_ERR: begin
        state_next = S_ERR;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

`ifdef DELAY_SLOT_EN
  logic        pend;
  logic [31:0] pend_target;

  // Taken branches inside the slot are ignored: a pending target always wins.
  always_comb begin
    if (pend)       pc_next = pend_target;
    else            pc_next = pc_seq;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend        <= 1'b0;
      pend_target <= '0;
    end else if (commit) begin
      if (pend) begin
        pend <= 1'b0;
      end else if (taken) begin
        pend        <= 1'b1;
        pend_target <= nextpc_in;
      end
    end
  end
`else
  always_comb begin
    pc_next = taken ? nextpc_in : pc_seq;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      inst_out <= '0;
    end else begin
      state <= state_next;
      if (commit)     pc       <= pc_next;
      if (latch_inst) inst_out <= imem_rdata;
    end
  end

  assign imem_addr  = pc;
  assign pc_out     = pc;
  assign imem_req   = (state == S_REQ) || (state == S_WAIT);
  assign inst_valid = (state == S_DEC);
  assign busy       = (state != S_IDLE) && (state != S_ERR);
  assign fetch_err  = (state == S_ERR);

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer; expectations follow the DELAY_SLOT_EN setting.
`timescale 1ns/1ps
module tb_pc_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rdy;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic        dec_valid, jump, br, zero, halt;
  logic [31:0] nextpc_in;
  logic        busy, fetch_err;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  pc_fetch_sequencer #(
    .RESET_PC (32'h0000_0000),
    .WAIT_MAX (15),
    .CNT_W    (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stall      (stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdy   (imem_rdy),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst_out   (inst_out),
    .pc_out     (pc_out),
    .dec_valid  (dec_valid),
    .jump       (jump),
    .br         (br),
    .zero       (zero),
    .halt       (halt),
    .nextpc_in  (nextpc_in),
    .busy       (busy),
    .fetch_err  (fetch_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start = 0; stall = 0; imem_rdy = 0; imem_rdata = '0;
    dec_valid = 0; jump = 0; br = 0; zero = 0; halt = 0; nextpc_in = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic start_fetch();
    start = 1;
    tick();
    start = 0;
  endtask

  // From REQ: return the word immediately, then commit with the given decode result.
  task automatic fetch_commit(input logic [31:0] data, input logic j, input logic b,
                              input logic z, input logic [31:0] npc, input logic h);
    imem_rdy = 1; imem_rdata = data;
    tick();
    imem_rdy = 0;
    dec_valid = 1; jump = j; br = b; zero = z; nextpc_in = npc; halt = h;
    tick();
    dec_valid = 0; jump = 0; br = 0; zero = 0; halt = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    #2;
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || pc_out !== 32'h0) begin
      failures++;
      $display("FAIL reset_pc: req=%0b addr=%h pc=%h expected req=0 addr=0 pc=0", imem_req, imem_addr, pc_out);
    end
    checks++;
    if (inst_valid !== 1'b0 || inst_out !== 32'h0 || busy !== 1'b0 || fetch_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: valid=%0b inst=%h busy=%0b err=%0b expected 0 0 0 0", inst_valid, inst_out, busy, fetch_err);
    end
    tick();
    reset = 0;
    imem_rdy = 1; dec_valid = 1; jump = 1; nextpc_in = 32'h80;
    tick();
    checks++;
    if (busy !== 1'b0 || imem_req !== 1'b0 || pc_out !== 32'h0) begin
      failures++;
      $display("FAIL idle_ignores: busy=%0b req=%0b pc=%h expected 0 0 0", busy, imem_req, pc_out);
    end
    clear_inputs();
  endtask

  task automatic test_sequential();
    do_reset();
    start_fetch();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'(4 * i) || busy !== 1'b1) begin
        failures++;
        $display("FAIL seq_req%0d: req=%0b addr=%h busy=%0b expected 1 %h 1", i, imem_req, imem_addr, busy, 32'(4 * i));
      end
      imem_rdy = 1; imem_rdata = 32'hA000_0000 + 32'(i);
      tick();
      imem_rdy = 0; dec_valid = 1;
      checks++;
      if (inst_valid !== 1'b1 || imem_req !== 1'b0 || inst_out !== 32'hA000_0000 + 32'(i) || pc_out !== 32'(4 * i)) begin
        failures++;
        $display("FAIL seq_dec%0d: valid=%0b req=%0b inst=%h pc=%h expected 1 0 %h %h",
                 i, inst_valid, imem_req, inst_out, pc_out, 32'hA000_0000 + 32'(i), 32'(4 * i));
      end
      tick();
      dec_valid = 0;
    end
    checks++;
    if (imem_addr !== 32'h10 || inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL seq_end: addr=%h valid=%0b expected 00000010 0", imem_addr, inst_valid);
    end
  endtask

  task automatic test_taken_branch();
    do_reset();
    start_fetch();
    fetch_commit(32'h1, 0, 0, 0, 32'h0, 0);
    fetch_commit(32'h2, 0, 0, 0, 32'h0, 0);
    fetch_commit(32'h3, 0, 1, 1, 32'h40, 0);
`ifdef DELAY_SLOT_EN
    checks++;
    if (imem_addr !== 32'hC) begin
      failures++;
      $display("FAIL br_slot: addr=%h expected 0000000c", imem_addr);
    end
    fetch_commit(32'h4, 1, 0, 0, 32'h80, 0);
    checks++;
    if (imem_addr !== 32'h40) begin
      failures++;
      $display("FAIL br_target: addr=%h expected 00000040", imem_addr);
    end
`else
    checks++;
    if (imem_addr !== 32'h40) begin
      failures++;
      $display("FAIL br_target: addr=%h expected 00000040", imem_addr);
    end
    fetch_commit(32'h4, 0, 0, 0, 32'h80, 0);
    checks++;
    if (imem_addr !== 32'h44) begin
      failures++;
      $display("FAIL br_after: addr=%h expected 00000044", imem_addr);
    end
`endif
  endtask

  task automatic test_not_taken_and_jump();
    do_reset();
    start_fetch();
    fetch_commit(32'h5, 0, 1, 0, 32'h40, 0);
    checks++;
    if (imem_addr !== 32'h4) begin
      failures++;
      $display("FAIL br_not_taken: addr=%h expected 00000004", imem_addr);
    end
    fetch_commit(32'h6, 1, 0, 0, 32'h123, 0);
`ifdef DELAY_SLOT_EN
    fetch_commit(32'h7, 0, 0, 0, 32'h0, 0);
`endif
    checks++;
    if (imem_addr !== 32'h123) begin
      failures++;
      $display("FAIL jump_verbatim: addr=%h expected 00000123", imem_addr);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    start_fetch();
    fetch_commit(32'h8, 1, 0, 0, 32'hFFFF_FFFC, 0);
`ifdef DELAY_SLOT_EN
    fetch_commit(32'h9, 0, 0, 0, 32'h0, 0);
`endif
    checks++;
    if (imem_addr !== 32'hFFFF_FFFC) begin
      failures++;
      $display("FAIL wrap_top: addr=%h expected fffffffc", imem_addr);
    end
    fetch_commit(32'hA, 0, 0, 0, 32'h0, 0);
    checks++;
    if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin
      failures++;
      $display("FAIL wrap_zero: addr=%h req=%0b expected 00000000 1", imem_addr, imem_req);
    end
  endtask

  task automatic test_wait();
    int unsigned bad = 0;
    do_reset();
    start_fetch();
    fetch_commit(32'h11, 0, 0, 0, 32'h0, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (imem_req !== 1'b1 || imem_addr !== 32'h4 || inst_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL wait_hold: bad_cycles=%0d expected 0 (req/addr steady at 00000004)", bad);
    end
    imem_rdy = 1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rdy = 0;
    checks++;
    if (inst_valid !== 1'b1 || inst_out !== 32'hDEAD_BEEF || imem_req !== 1'b0) begin
      failures++;
      $display("FAIL wait_dec: valid=%0b inst=%h req=%0b expected 1 deadbeef 0", inst_valid, inst_out, imem_req);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    start_fetch();
    tick();
    repeat (14) tick();
    checks++;
    if (fetch_err !== 1'b0 || imem_req !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL timeout_early: err=%0b req=%0b busy=%0b expected 0 1 1", fetch_err, imem_req, busy);
    end
    tick();
    checks++;
    if (fetch_err !== 1'b1 || imem_req !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_err: err=%0b req=%0b busy=%0b expected 1 0 0", fetch_err, imem_req, busy);
    end
    start = 1; imem_rdy = 1;
    tick();
    tick();
    clear_inputs();
    checks++;
    if (fetch_err !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL timeout_sticky: err=%0b req=%0b valid=%0b expected 1 0 0", fetch_err, imem_req, inst_valid);
    end
  endtask

  task automatic test_stall_halt();
    int unsigned bad = 0;
    do_reset();
    start_fetch();
    fetch_commit(32'h21, 0, 0, 0, 32'h0, 0);
    imem_rdy = 1; imem_rdata = 32'h1234_5678;
    tick();
    imem_rdy = 0; imem_rdata = 32'hFFFF_0000;
    stall = 1; dec_valid = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (pc_out !== 32'h4 || inst_out !== 32'h1234_5678 || inst_valid !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL stall_hold: bad_cycles=%0d expected 0 (pc 00000004 inst 12345678)", bad);
    end
    stall = 0; halt = 1;
    tick();
    dec_valid = 0; halt = 0;
    checks++;
    if (busy !== 1'b0 || inst_valid !== 1'b0 || imem_req !== 1'b0 || pc_out !== 32'h8) begin
      failures++;
      $display("FAIL halt_idle: busy=%0b valid=%0b req=%0b pc=%h expected 0 0 0 00000008", busy, inst_valid, imem_req, pc_out);
    end
    tick();
    start_fetch();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h8 || busy !== 1'b1) begin
      failures++;
      $display("FAIL restart: req=%0b addr=%h busy=%0b expected 1 00000008 1", imem_req, imem_addr, busy);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    start_fetch();
    fetch_commit(32'h31, 0, 0, 0, 32'h0, 0);
    tick();
    reset = 1;
    #1;
    checks++;
    if (imem_req !== 1'b0 || pc_out !== 32'h0 || busy !== 1'b0 || inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: req=%0b pc=%h busy=%0b valid=%0b expected 0 0 0 0", imem_req, pc_out, busy, inst_valid);
    end
    tick();
    reset = 0;
    imem_rdy = 1; imem_rdata = 32'h5555_AAAA;
    tick();
    imem_rdy = 0;
    checks++;
    if (inst_valid !== 1'b0 || inst_out !== 32'h0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_discard: valid=%0b inst=%h busy=%0b expected 0 00000000 0", inst_valid, inst_out, busy);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_taken_branch();
    test_not_taken_and_jump();
    test_wrap();
    test_wait();
    test_timeout();
    test_stall_halt();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
